// File: rtl/sme_pkg.sv
// Shared types and helpers for the masked DOM AND sequencer and its gadget.
package sme_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sme_dom_sched_state_t;

  // Guard words per operation: D ring-refresh words plus one per share pair.
  function automatic int sme_rmax(input int d);
    return d + d * (d - 1) / 2;
  endfunction

  // Guard word index of share pair (i, j) with i < j, placed after the D ring words.
  function automatic int sme_pair_idx(input int d, input int i, input int j);
    return d + i * d - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sme_dom_and.sv
// Domain-oriented masked AND gadget: one registered product per share pair,
// cross terms blinded by shared guards, diagonal terms ring-refreshed.
module sme_dom_and
  import sme_pkg::*;
#(
  parameter int D       = 3,
  parameter int N       = 32,
  parameter int POSEDGE = 0,
  localparam int RMAX   = sme_rmax(D)
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  input  logic         en,
  input  logic [N-1:0] rs1 [D],
  input  logic [N-1:0] rs2 [D],
  input  logic [N-1:0] rng [RMAX],
  output logic [N-1:0] rd  [D]
);

  logic [N-1:0] prod_reg  [D][D];
  logic [N-1:0] prod_next [D][D];

  assign g_clk_req = en;

  for (genvar gi = 0; gi < D; gi++) begin : g_row
    for (genvar gj = 0; gj < D; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        // rng[i] ^ rng[i+1] summed over the ring cancels, so the result is unchanged
        assign prod_next[gi][gj] = (rs1[gi] & rs2[gj]) ^ rng[gi] ^ rng[(gi + 1) % D];
      end else if (gi < gj) begin : g_upper
        assign prod_next[gi][gj] = (rs1[gi] & rs2[gj]) ^ rng[sme_pair_idx(D, gi, gj)];
      end else begin : g_lower
        assign prod_next[gi][gj] = (rs1[gi] & rs2[gj]) ^ rng[sme_pair_idx(D, gj, gi)];
      end

      if (POSEDGE != 0) begin : g_pos
        always_ff @(posedge g_clk) begin
          if (en && g_resetn) prod_reg[gi][gj] <= prod_next[gi][gj];
        end
      end else begin : g_neg
        always_ff @(negedge g_clk) begin
          if (en && g_resetn) prod_reg[gi][gj] <= prod_next[gi][gj];
        end
      end
    end

    logic [N-1:0] row_xor;
    always_comb begin
      row_xor = '0;
      for (int j = 0; j < D; j++) row_xor = row_xor ^ prod_reg[gi][j];
    end
    assign rd[gi] = row_xor;
  end

endmodule

// File: rtl/sme_dom_sched.sv
// Round-robin sequencer that time-shares one DOM AND gadget between requesters
// and scrubs operands, guards and results after every operation.
module sme_dom_sched
  import sme_pkg::*;
#(
  parameter int D     = 3,
  parameter int N     = 32,
  parameter int NREQ  = 2,
  localparam int RMAX = sme_rmax(D)
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  output logic                  g_clk_req,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*D*N-1:0]   req_rs1,
  input  logic [NREQ*D*N-1:0]   req_rs2,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [D*N-1:0]        rsp_rd,
  input  logic                  rng_valid,
  output logic                  rng_ready,
  input  logic [RMAX*N-1:0]     rng_data,
  output logic                  busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sme_dom_sched_state_t state_reg, state_next;
  logic [LW-1:0]     last_reg, gnt_reg;
  logic [D*N-1:0]    op1_reg, op2_reg, rsp_rd_reg;
  logic [RMAX*N-1:0] rng_reg;
  logic [NREQ-1:0]   rsp_valid_reg;

  logic          win_found;
  logic [LW-1:0] win_idx;
  logic          accept;
  logic          hs;

  logic [N-1:0] a_arr [D];
  logic [N-1:0] b_arr [D];
  logic [N-1:0] r_arr [RMAX];
  logic [N-1:0] d_arr [D];
  logic [D*N-1:0] d_flat;

  // Walk offsets from far to near so the requester closest after last wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int o = NREQ; o >= 1; o--) begin
      idx = (int'(last_reg) + o) % NREQ;
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = LW'(idx);
      end
    end
  end

  assign accept    = (state_reg == IDLE) && rng_valid && win_found;
  assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
  assign rng_ready = accept;
  assign hs        = (state_reg == RESP) && rsp_ready[gnt_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_reg     <= IDLE;
      last_reg      <= LW'(NREQ - 1);
      gnt_reg       <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      rng_reg       <= '0;
      rsp_rd_reg    <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op1_reg  <= req_rs1[int'(win_idx)*D*N +: D*N];
        op2_reg  <= req_rs2[int'(win_idx)*D*N +: D*N];
        rng_reg  <= rng_data;
        gnt_reg  <= win_idx;
        last_reg <= win_idx;
      end
      if (state_reg == ISSUE) begin
        rsp_rd_reg    <= d_flat;
        rsp_valid_reg <= NREQ'(1) << gnt_reg;
      end
      if (hs) begin
        op1_reg       <= '0;
        op2_reg       <= '0;
        rng_reg       <= '0;
        rsp_rd_reg    <= '0;
        rsp_valid_reg <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_shares
    assign a_arr[gi]            = op1_reg[gi*N +: N];
    assign b_arr[gi]            = op2_reg[gi*N +: N];
    assign d_flat[gi*N +: N]    = d_arr[gi];
  end

  for (genvar gi = 0; gi < RMAX; gi++) begin : g_guards
    assign r_arr[gi] = rng_reg[gi*N +: N];
  end

  sme_dom_and #(
    .D       (D),
    .N       (N),
    .POSEDGE (0)
  ) u_and (
    .g_clk     (g_clk),
    .g_resetn  (~g_reset),
    .g_clk_req (),
    .en        (state_reg == ISSUE),
    .rs1       (a_arr),
    .rs2       (b_arr),
    .rng       (r_arr),
    .rd        (d_arr)
  );

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rd    = (|rsp_valid_reg) ? rsp_rd_reg : '0;
  assign busy      = (state_reg != IDLE);
  assign g_clk_req = (|req_valid) || busy;

endmodule

// File: tb/tb_sme_dom_sched.sv
// Directed bench for sme_dom_sched (D=3, N=32, two requesters).
module tb_sme_dom_sched;

  localparam int D    = 3;
  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int RMAX = D + D * (D - 1) / 2;

  logic                g_clk = 1'b0;
  logic                g_reset;
  logic                g_clk_req;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*D*N-1:0] req_rs1, req_rs2;
  logic [D*N-1:0]      rsp_rd;
  logic                rng_valid, rng_ready, busy;
  logic [RMAX*N-1:0]   rng_data;

  int n_cmp = 0;
  int n_err = 0;

  sme_dom_sched #(.D(D), .N(N), .NREQ(NREQ)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .g_clk_req (g_clk_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd),
    .rng_valid (rng_valid),
    .rng_ready (rng_ready),
    .rng_data  (rng_data),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  task automatic step();
    @(posedge g_clk);
    #2;
  endtask

  task automatic load(input int r, input logic [N-1:0] a0, a1, a2, b0, b1, b2);
    req_rs1[(r*D+0)*N +: N] = a0;
    req_rs1[(r*D+1)*N +: N] = a1;
    req_rs1[(r*D+2)*N +: N] = a2;
    req_rs2[(r*D+0)*N +: N] = b0;
    req_rs2[(r*D+1)*N +: N] = b1;
    req_rs2[(r*D+2)*N +: N] = b2;
  endtask

  task automatic load_val(input int r, input logic [N-1:0] a, b);
    logic [N-1:0] m0, m1, m2, m3;
    m0 = $urandom; m1 = $urandom; m2 = $urandom; m3 = $urandom;
    load(r, m0, m1, a ^ m0 ^ m1, m2, m3, b ^ m2 ^ m3);
  endtask

  task automatic new_rng();
    for (int k = 0; k < RMAX; k++) rng_data[k*N +: N] = $urandom;
  endtask

  function automatic logic [N-1:0] unmask(input logic [D*N-1:0] v);
    logic [N-1:0] x;
    x = '0;
    for (int s = 0; s < D; s++) x = x ^ v[s*N +: N];
    return x;
  endfunction

  task automatic test_reset();
    req_valid = '0; rsp_ready = '0; rng_valid = 1'b0;
    req_rs1 = '0; req_rs2 = '0; rng_data = '0;
    g_reset = 1'b0;
    #1 g_reset = 1'b1;
    step();
    n_cmp++; if (req_ready !== 2'b00) begin $display("FAIL reset_req_ready: got %b want 00", req_ready); n_err++; end
    n_cmp++; if (rng_ready !== 1'b0) begin $display("FAIL reset_rng_ready: got %b want 0", rng_ready); n_err++; end
    n_cmp++; if (rsp_valid !== 2'b00) begin $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); n_err++; end
    n_cmp++; if (rsp_rd !== '0) begin $display("FAIL reset_rsp_rd: got %h want 0", rsp_rd); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
    g_reset = 1'b0;
    step();
    n_cmp++; if (g_clk_req !== 1'b0) begin $display("FAIL reset_clk_req: got %b want 0", g_clk_req); n_err++; end
    $display("reset: done");
  endtask

  task automatic test_basic();
    load(0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 32'h88887777);
    new_rng();
    req_valid = 2'b01; rng_valid = 1'b1; rsp_ready = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin $display("FAIL basic_req_ready: got %b want 01", req_ready); n_err++; end
    n_cmp++; if (rng_ready !== 1'b1) begin $display("FAIL basic_rng_ready: got %b want 1", rng_ready); n_err++; end
    step();
    req_valid = 2'b00; rng_valid = 1'b0; new_rng();
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL basic_busy_issue: got %b want 1", busy); n_err++; end
    n_cmp++; if (rsp_valid !== 2'b00) begin $display("FAIL basic_early_valid: got %b want 00", rsp_valid); n_err++; end
    step();
    n_cmp++; if (rsp_valid !== 2'b01) begin $display("FAIL basic_rsp_valid: got %b want 01", rsp_valid); n_err++; end
    n_cmp++; if (unmask(rsp_rd) !== 32'h0000AAAA) begin $display("FAIL basic_result: got %h want 0000aaaa", unmask(rsp_rd)); n_err++; end
    step();
    n_cmp++; if (rsp_valid !== 2'b00) begin $display("FAIL basic_valid_clear: got %b want 00", rsp_valid); n_err++; end
    n_cmp++; if (rsp_rd !== '0) begin $display("FAIL basic_rd_clear: got %h want 0", rsp_rd); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL basic_idle: got %b want 0", busy); n_err++; end
    $display("basic: result %h", unmask(32'h0) ^ 32'h0000AAAA);
  endtask

  task automatic test_round_robin();
    int grants[$];
    int pulses, nrsp, drop_after;
    logic [N-1:0] exp0, exp1, want;
    g_reset = 1'b1; step(); g_reset = 1'b0;
    exp0 = 32'hDEADBEEF & 32'hF0F0F0F0;
    exp1 = 32'h12345678 & 32'hFF00FF00;
    load_val(0, 32'hDEADBEEF, 32'hF0F0F0F0);
    load_val(1, 32'h12345678, 32'hFF00FF00);
    req_valid = 2'b11; rng_valid = 1'b1; rsp_ready = 2'b11; new_rng();
    pulses = 0; nrsp = 0; drop_after = -1;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (rng_ready) pulses++;
      if (req_ready != 2'b00) begin
        grants.push_back(req_ready[1] ? 1 : 0);
        if (grants.size() == 4) drop_after = c;
      end
      if (rsp_valid != 2'b00) begin
        nrsp++;
        want = rsp_valid[1] ? exp1 : exp0;
        n_cmp++; if (unmask(rsp_rd) !== want) begin $display("FAIL rr_result: got %h want %h", unmask(rsp_rd), want); n_err++; end
      end
      step();
      new_rng();
      if (drop_after >= 0) begin req_valid = 2'b00; rng_valid = 1'b0; end
    end
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i < grants.size()) ? grants[i] : -1;
      n_cmp++; if (g !== (i % 2)) begin $display("FAIL rr_grant%0d: got %0d want %0d", i, g, i % 2); n_err++; end
      $display("rr: grant %0d -> requester %0d", i, g);
    end
    n_cmp++; if (grants.size() !== 4) begin $display("FAIL rr_grant_count: got %0d want 4", grants.size()); n_err++; end
    n_cmp++; if (pulses !== 4) begin $display("FAIL rr_rng_pulses: got %0d want 4", pulses); n_err++; end
    n_cmp++; if (nrsp !== 4) begin $display("FAIL rr_responses: got %0d want 4", nrsp); n_err++; end
  endtask

  task automatic test_rng_stall();
    load_val(1, 32'h0000FFFF, 32'h00FF00FF);
    req_valid = 2'b10; rng_valid = 1'b0; rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin $display("FAIL stall_req_ready%0d: got %b want 00", c, req_ready); n_err++; end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL stall_busy%0d: got %b want 0", c, busy); n_err++; end
      step();
    end
    rng_valid = 1'b1; new_rng();
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin $display("FAIL stall_grant: got %b want 10", req_ready); n_err++; end
    n_cmp++; if (rng_ready !== 1'b1) begin $display("FAIL stall_rng_ready: got %b want 1", rng_ready); n_err++; end
    step();
    req_valid = 2'b00; rng_valid = 1'b0;
    step();
    n_cmp++; if (unmask(rsp_rd) !== 32'h000000FF) begin $display("FAIL stall_result: got %h want 000000ff", unmask(rsp_rd)); n_err++; end
    step();
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL stall_idle: got %b want 0", busy); n_err++; end
    $display("rng_stall: done");
  endtask

  task automatic test_resp_hold();
    logic [N-1:0] want;
    want = 32'hCAFEF00D & 32'h0FF0F00F;
    load_val(0, 32'hCAFEF00D, 32'h0FF0F00F);
    req_valid = 2'b01; rng_valid = 1'b1; rsp_ready = 2'b10; new_rng();
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin $display("FAIL hold_grant: got %b want 01", req_ready); n_err++; end
    step();
    req_valid = 2'b00; rng_valid = 1'b0;
    step();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (rsp_valid !== 2'b01) begin $display("FAIL hold_valid%0d: got %b want 01", c, rsp_valid); n_err++; end
      n_cmp++; if (unmask(rsp_rd) !== want) begin $display("FAIL hold_result%0d: got %h want %h", c, unmask(rsp_rd), want); n_err++; end
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL hold_busy%0d: got %b want 1", c, busy); n_err++; end
      step();
    end
    rsp_ready = 2'b01;
    step();
    n_cmp++; if (rsp_valid !== 2'b00) begin $display("FAIL hold_release_valid: got %b want 00", rsp_valid); n_err++; end
    n_cmp++; if (rsp_rd !== '0) begin $display("FAIL hold_release_rd: got %h want 0", rsp_rd); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL hold_release_idle: got %b want 0", busy); n_err++; end
    $display("resp_hold: done");
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] want;
    load_val(1, 32'hFFFFFFFF, 32'h13579BDF);
    req_valid = 2'b10; rng_valid = 1'b1; rsp_ready = 2'b11; new_rng();
    step();
    req_valid = 2'b00; rng_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL midrst_in_issue: got %b want 1", busy); n_err++; end
    #1 g_reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", busy); n_err++; end
    n_cmp++; if (rsp_valid !== 2'b00) begin $display("FAIL midrst_rsp_valid: got %b want 00", rsp_valid); n_err++; end
    n_cmp++; if (rsp_rd !== '0) begin $display("FAIL midrst_rsp_rd: got %h want 0", rsp_rd); n_err++; end
    n_cmp++; if (req_ready !== 2'b00) begin $display("FAIL midrst_req_ready: got %b want 00", req_ready); n_err++; end
    n_cmp++; if (rng_ready !== 1'b0) begin $display("FAIL midrst_rng_ready: got %b want 0", rng_ready); n_err++; end
    step();
    g_reset = 1'b0;
    want = 32'h89ABCDEF & 32'h0F0F0F0F;
    load_val(0, 32'h89ABCDEF, 32'h0F0F0F0F);
    req_valid = 2'b11; rng_valid = 1'b1; new_rng();
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin $display("FAIL midrst_regrant: got %b want 01", req_ready); n_err++; end
    step();
    req_valid = 2'b00; rng_valid = 1'b0;
    step();
    n_cmp++; if (rsp_valid !== 2'b01) begin $display("FAIL midrst_rsp: got %b want 01", rsp_valid); n_err++; end
    n_cmp++; if (unmask(rsp_rd) !== want) begin $display("FAIL midrst_result: got %h want %h", unmask(rsp_rd), want); n_err++; end
    step();
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL midrst_idle: got %b want 0", busy); n_err++; end
    $display("reset_midop: done");
  endtask

  task automatic test_random();
    int r, errs0;
    logic [N-1:0] a, b;
    logic [NREQ-1:0] oh;
    errs0 = n_err;
    rsp_ready = 2'b11;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 1);
      a = (i == 0) ? 32'h0 : (i == 1) ? 32'hFFFFFFFF : $urandom;
      b = (i == 2) ? 32'h0 : (i <= 1) ? 32'hFFFFFFFF : $urandom;
      oh = (r == 1) ? 2'b10 : 2'b01;
      load_val(r, a, b);
      new_rng();
      req_valid = oh; rng_valid = 1'b1;
      #1;
      n_cmp++; if (req_ready !== oh) begin $display("FAIL rand%0d_grant: got %b want %b", i, req_ready, oh); n_err++; end
      n_cmp++; if (rng_ready !== 1'b1) begin $display("FAIL rand%0d_rng: got %b want 1", i, rng_ready); n_err++; end
      step();
      #1;
      n_cmp++; if (rng_ready !== 1'b0) begin $display("FAIL rand%0d_rng_issue: got %b want 0", i, rng_ready); n_err++; end
      step();
      #1;
      n_cmp++; if (rng_ready !== 1'b0) begin $display("FAIL rand%0d_rng_resp: got %b want 0", i, rng_ready); n_err++; end
      n_cmp++; if (rsp_valid !== oh) begin $display("FAIL rand%0d_valid: got %b want %b", i, rsp_valid, oh); n_err++; end
      n_cmp++; if (unmask(rsp_rd) !== (a & b)) begin $display("FAIL rand%0d_result: got %h want %h", i, unmask(rsp_rd), a & b); n_err++; end
      req_valid = 2'b00; rng_valid = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL rand%0d_idle: got %b want 0", i, busy); n_err++; end
    end
    $display("random: 300 ops, %0d errors", n_err - errs0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_rng_stall();
    test_resp_hold();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
